ex_muldiv_seq: RTL
==================

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL use one clock and synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have port Flush in 1: CP0 flush, aborts the in-flight operation.
REQ-003 SHALL have port Start in 1: the EX instruction requests an operation this cycle.
REQ-004 SHALL have port Op in 3: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP.
REQ-005 SHALL have ports Rs in 32 and Rt in 32: forwarded operands (RsFwdOut/RtFwdLinkOut).
REQ-006 SHALL have port HiLoRead in 1: the EX instruction is MFHI/MFLO.
REQ-007 SHALL have ports Hi out 32 and Lo out 32: architectural HI/LO registers.
REQ-008 SHALL have port Busy out 1: an iterative operation is in flight.
REQ-009 SHALL have port ALUStall out 1: stall request to the hazard controller.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and FIX.
REQ-011 In IDLE, Start with Op 1-4 and Flush=0 SHALL latch the operands, load the 5-bit counter with 31 and enter RUN.
REQ-012 RUN SHALL perform one iteration per cycle (multiply: shift-add on |operands|; divide: restoring on |operands|), decrement the counter, and enter FIX after the iteration with counter==0 (32 iterations).
REQ-013 FIX SHALL apply sign correction for MULT/DIV, write Hi/Lo, and return to IDLE; Hi/Lo SHALL be visible in the cycle after FIX, i.e. 34 cycles after the accepting edge.
REQ-014 Multiply SHALL produce Hi:Lo = the 64-bit product, signed for MULT and unsigned for MULTU.
REQ-015 Divide SHALL produce Lo = quotient truncated toward zero and Hi = remainder carrying the sign of the dividend.
REQ-016 When the divisor is 0, divide SHALL run the full latency and produce Lo=32'hFFFFFFFF, Hi=Rs.
REQ-017 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce Lo=32'h80000000, Hi=0.
REQ-018 MTHI/MTLO SHALL be accepted only in IDLE with Flush=0 and SHALL write Hi or Lo, respectively, at the next edge.
REQ-019 Busy SHALL be 1 exactly when the state is RUN or FIX.
REQ-020 ALUStall SHALL equal Busy && (HiLoRead || (Start && Op in 1-6)), combinationally.
REQ-021 A Start while Busy SHALL be ignored; the pipeline re-presents the instruction once the stall drops.
REQ-022 Flush in RUN or FIX SHALL return the FSM to IDLE at the next edge with Hi/Lo unchanged; Flush has priority over a FIX write in the same cycle.
REQ-023 Flush together with Start in IDLE SHALL leave the operation unaccepted.
REQ-024 Start with Op 0 or 7 SHALL have no effect.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, Hi=0, Lo=0, Busy=0, ALUStall=0 and clear the operand/accumulator registers.
REQ-026 rst SHALL take priority over Flush and Start and SHALL abort any operation mid-run.

Configuration
REQ-027 With MULDIV_DIV_EN defined, DIV/DIVU SHALL behave per REQ-012 to REQ-017.
REQ-028 Without MULDIV_DIV_EN, Op 3/4 SHALL be treated as NOP: Hi/Lo unchanged, Busy never asserted, and no divider logic synthesized.

Structure
REQ-029 A shared package SHALL hold the Op encoding enum, the FSM state enum, and the localparams for width 32 and iteration count 32.
REQ-030 The iterative datapath SHALL be a single sub-module, ex_muldiv_core (accumulator, shift, add/subtract); ex_muldiv_seq owns the FSM, counter, Hi/Lo and stall logic.

Verification
REQ-031 MULT Rs=32'hFFFFFFFE, Rt=3 SHALL yield Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA 34 cycles after accept, with Busy high for 33 cycles.
REQ-032 MULTU Rs=Rt=32'hFFFFFFFF SHALL yield Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-033 DIV Rs=-7, Rt=2 SHALL yield Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU by 0 with Rs=5 SHALL yield Lo=32'hFFFFFFFF, Hi=5.
REQ-034 HiLoRead asserted 2 cycles after a MULT accept SHALL hold ALUStall=1 until Busy falls; an MTLO presented while Busy SHALL stall and then write Lo after the stall.
REQ-035 Flush at iteration 10 of MULT after prior Hi=Lo=32'h12345678 SHALL return to IDLE the next cycle with Hi/Lo still 32'h12345678.
REQ-036 rst asserted mid-DIV SHALL produce Hi=Lo=0 and Busy=0 on the next cycle; a new MULT SHALL then complete correctly.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// ex_muldiv_seq shared types: op encoding, FSM states, widths.
// Optional divider is enabled by defining MULDIV_DIV_EN.
package ex_muldiv_seq_pkg;

  localparam int dataWidth = 32;
  localparam int iterCount = 32;
  localparam int cntWidth  = $clog2(iterCount);

  typedef logic [dataWidth-1:0] wordT;

  typedef enum logic [2:0] {
    opNop   = 3'd0,
    opMult  = 3'd1,
    opMultu = 3'd2,
    opDiv   = 3'd3,
    opDivu  = 3'd4,
    opMthi  = 3'd5,
    opMtlo  = 3'd6,
    opRsv   = 3'd7
  } opE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateE;

  // Absolute value for signed ops, identity otherwise.
  function automatic wordT magnitude(
    input wordT v,
    input logic signedOp
  );
    return (signedOp && v[dataWidth-1]) ? wordT'(-v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage to mul/div unit bundle.
// Pipeline side is master, the unit is slave.
interface ex_muldiv_seq_if;
  import ex_muldiv_seq_pkg::*;

  logic       Flush;
  logic       Start;
  logic [2:0] Op;
  wordT       Rs;
  wordT       Rt;
  logic       HiLoRead;
  wordT       Hi;
  wordT       Lo;
  logic       Busy;
  logic       ALUStall;

  modport master (
    output Flush, Start, Op, Rs, Rt, HiLoRead,
    input  Hi, Lo, Busy, ALUStall
  );

  modport slave (
    input  Flush, Start, Op, Rs, Rt, HiLoRead,
    output Hi, Lo, Busy, ALUStall
  );

endinterface

// File: rtl/ex_muldiv_core.sv
// Iterative mul/div datapath: shift-add and restoring divide.
// Divide path exists only with MULDIV_DIV_EN defined.
module ex_muldiv_core
  import ex_muldiv_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
`ifdef MULDIV_DIV_EN
  input  logic divIn,
`endif
  input  wordT aIn,
  input  wordT bIn,
  output wordT accHi,
  output wordT accLo
);

  wordT opB;
  wordT nextHi;
  wordT nextLo;
  logic [dataWidth:0] mulSum;

  assign mulSum = {1'b0, accHi}
                + (accLo[0] ? {1'b0, opB} : '0);

`ifdef MULDIV_DIV_EN
  logic divMode;
  logic [dataWidth:0] shifted;
  logic fits;
  wordT diffLo;

  assign shifted = {accHi, accLo[dataWidth-1]};
  assign fits    = shifted >= {1'b0, opB};
  assign diffLo  = shifted[dataWidth-1:0] - opB;

  // One iteration: multiply step unless in divide mode.
  always_comb begin
    nextHi = mulSum[dataWidth:1];
    nextLo = {mulSum[0], accLo[dataWidth-1:1]};
    if (divMode) begin
      nextHi = fits ? diffLo : shifted[dataWidth-1:0];
      nextLo = {accLo[dataWidth-2:0], fits};
    end
  end
`else
  assign nextHi = mulSum[dataWidth:1];
  assign nextLo = {mulSum[0], accLo[dataWidth-1:1]};
`endif

  // Accumulator: cleared on load, one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      accHi <= '0;
      accLo <= '0;
      opB   <= '0;
`ifdef MULDIV_DIV_EN
      divMode <= 1'b0;
`endif
    end else if (load) begin
      accHi <= '0;
      accLo <= aIn;
      opB   <= bIn;
`ifdef MULDIV_DIV_EN
      divMode <= divIn;
`endif
    end else if (step) begin
      accHi <= nextHi;
      accLo <= nextLo;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequential MIPS HI/LO unit: FSM, counter, HI/LO, stall.
// Define MULDIV_DIV_EN to build DIV/DIVU support.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_muldiv_seq_if.slave bus
);

  stateE state;
  logic [cntWidth-1:0] cnt;
  wordT hiQ;
  wordT loQ;
  logic fixDiv;
  logic negA;
  logic negB;

  opE   op;
  logic isMul;
  logic isDiv;
  logic signedOp;
  logic accept;
  logic mtAccept;
  logic busy;
  logic signDiff;
  wordT aMag;
  wordT bMag;
  wordT coreHi;
  wordT coreLo;
  logic [2*dataWidth-1:0] prodFix;
  wordT quot;
  wordT rem;

  assign op    = opE'(bus.Op);
  assign isMul = (op == opMult) || (op == opMultu);
`ifdef MULDIV_DIV_EN
  assign isDiv = (op == opDiv) || (op == opDivu);
`else
  assign isDiv = 1'b0;
`endif
  assign signedOp = (op == opMult) || (op == opDiv);
  assign signDiff = bus.Rs[dataWidth-1] ^ bus.Rt[dataWidth-1];

  assign mtAccept = (state == IDLE) && bus.Start && !bus.Flush;
  assign accept   = mtAccept && (isMul || isDiv);

  assign aMag = magnitude(bus.Rs, signedOp);
  assign bMag = magnitude(bus.Rt, signedOp);

  ex_muldiv_core uCore (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (state == RUN),
`ifdef MULDIV_DIV_EN
    .divIn (isDiv),
`endif
    .aIn   (aMag),
    .bIn   (bMag),
    .accHi (coreHi),
    .accLo (coreLo)
  );

  assign prodFix = negA ? -{coreHi, coreLo}
                        : {coreHi, coreLo};
  assign quot = negA ? wordT'(-coreLo) : coreLo;
  assign rem  = negB ? wordT'(-coreHi) : coreHi;

  assign busy = (state == RUN) || (state == FIX);

  assign bus.Hi       = hiQ;
  assign bus.Lo       = loQ;
  assign bus.Busy     = busy;
  assign bus.ALUStall = busy && (bus.HiLoRead ||
                        (bus.Start && op != opNop
                                   && op != opRsv));

  // Control FSM; flush drops the op, FIX writes HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      fixDiv <= 1'b0;
      negA   <= 1'b0;
      negB   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            cnt    <= cntWidth'(iterCount - 1);
            fixDiv <= isDiv;
            negA   <= signedOp && signDiff
                      && (!isDiv || (|bus.Rt));
            negB   <= signedOp && bus.Rs[dataWidth-1];
          end else if (mtAccept && op == opMthi) begin
            hiQ <= bus.Rs;
          end else if (mtAccept && op == opMtlo) begin
            loQ <= bus.Rs;
          end
        end
        RUN: begin
          if (bus.Flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.Flush) begin
            if (fixDiv) begin
              hiQ <= rem;
              loQ <= quot;
            end else begin
              {hiQ, loQ} <= prodFix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
